// File: rtl/ram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ram_port_arbiter_pkg
//  Purpose  : Shared types, legal write-enable encodings and the misalignment
//             check used by the RAM port arbiter and the RAM's sim check.
//  Revision : 1.0 - initial release
// ============================================================================
package ram_port_arbiter_pkg;

    localparam logic [3:0] c_WE_READ = 4'b0000;
    localparam logic [3:0] c_WE_BYTE = 4'b0001;
    localparam logic [3:0] c_WE_HALF = 4'b0011;
    localparam logic [3:0] c_WE_WORD = 4'b1111;

    typedef enum logic {
        MST_0 = 1'b0,
        MST_1 = 1'b1
    } mst_idx_e;

    // True for any write the byte-lane RAM cannot perform in one access.
    function automatic logic is_misaligned(input logic [3:0] we, input logic [1:0] addr_lo);
        logic legal_we;
        legal_we = (we == c_WE_READ) || (we == c_WE_BYTE) ||
                   (we == c_WE_HALF) || (we == c_WE_WORD);
        return !legal_we ||
               ((we == c_WE_WORD) && (addr_lo != 2'd0)) ||
               ((we == c_WE_HALF) && (addr_lo == 2'd3));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_port_arbiter
//  Purpose  : Round-robin sharing of one byte-lane RAM port between two
//             masters, with single-cycle grant and a one-cycle return pipe.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int SCALE = 10
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             m0_req,
    input  logic [SCALE-1:0] m0_addr,
    input  logic [31:0]      m0_wdata,
    input  logic [3:0]       m0_we,
    output logic             m0_gnt,
    output logic             m0_rvalid,
    output logic [31:0]      m0_rdata,

    input  logic             m1_req,
    input  logic [SCALE-1:0] m1_addr,
    input  logic [31:0]      m1_wdata,
    input  logic [3:0]       m1_we,
    output logic             m1_gnt,
    output logic             m1_rvalid,
    output logic [31:0]      m1_rdata,

    output logic             ram_oe,
    output logic [SCALE-1:0] ram_addr,
    output logic [31:0]      ram_wdata,
    output logic [3:0]       ram_we,
    input  logic [31:0]      ram_rdata,

    output logic             err,
    output logic             err_src
);

    mst_idx_e         r_lg_q,      w_lg_d;
    logic             r_rvalid_q,  w_rvalid_d;
    mst_idx_e         r_owner_q,   w_owner_d;
    logic             r_blk_q,     w_blk_d;
    logic             r_err_q,     w_err_d;
    mst_idx_e         r_err_src_q, w_err_src_d;

    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_any;
    logic             w_mis;
    mst_idx_e         w_idx;
    logic [SCALE-1:0] w_sel_addr;
    logic [31:0]      w_sel_wdata;
    logic [3:0]       w_sel_we;

    // Round-robin pick: under contention the master that did not win last time goes.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            if (m0_req && m1_req) begin
                w_gnt0 = (r_lg_q == MST_1);
                w_gnt1 = (r_lg_q == MST_0);
            end else begin
                w_gnt0 = m0_req;
                w_gnt1 = m1_req;
            end
        end
        w_any = w_gnt0 | w_gnt1;
        w_idx = w_gnt1 ? MST_1 : MST_0;
    end

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = '0;
        if (w_gnt0) begin
            w_sel_addr  = m0_addr;
            w_sel_wdata = m0_wdata;
            w_sel_we    = m0_we;
        end else if (w_gnt1) begin
            w_sel_addr  = m1_addr;
            w_sel_wdata = m1_wdata;
            w_sel_we    = m1_we;
        end
        w_mis = w_any && is_misaligned(w_sel_we, w_sel_addr[1:0]);
    end

    always_comb begin
        w_lg_d      = w_any ? w_idx : r_lg_q;
        w_rvalid_d  = w_any;
        w_owner_d   = w_idx;
        w_blk_d     = w_mis;
        w_err_d     = r_err_q | w_mis;
        w_err_src_d = (w_mis && !r_err_q) ? w_idx : r_err_src_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lg_q      <= MST_1;
            r_rvalid_q  <= 1'b0;
            r_owner_q   <= MST_0;
            r_blk_q     <= 1'b0;
            r_err_q     <= 1'b0;
            r_err_src_q <= MST_0;
        end else begin
            r_lg_q      <= w_lg_d;
            r_rvalid_q  <= w_rvalid_d;
            r_owner_q   <= w_owner_d;
            r_blk_q     <= w_blk_d;
            r_err_q     <= w_err_d;
            r_err_src_q <= w_err_src_d;
        end
    end

    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    assign ram_oe    = w_any && !w_mis;
    assign ram_addr  = w_sel_addr;
    assign ram_wdata = w_sel_wdata;
    assign ram_we    = w_sel_we;

    // Gating by rst discards a return still in flight when reset lands on it.
    assign m0_rvalid = !rst && r_rvalid_q && (r_owner_q == MST_0);
    assign m1_rvalid = !rst && r_rvalid_q && (r_owner_q == MST_1);
    assign m0_rdata  = (m0_rvalid && !r_blk_q) ? ram_rdata : 32'd0;
    assign m1_rdata  = (m1_rvalid && !r_blk_q) ? ram_rdata : 32'd0;

    assign err     = r_err_q;
    assign err_src = r_err_src_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_port_arbiter
//  Purpose  : Self-checking bench for ram_port_arbiter with a behavioural RAM
//             and a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

    localparam int SCALE = 10;
    localparam int WORDS = 2 ** (SCALE - 2);

    logic             clk = 1'b0;
    logic             rst;
    logic             m0_req, m1_req;
    logic [SCALE-1:0] m0_addr, m1_addr;
    logic [31:0]      m0_wdata, m1_wdata;
    logic [3:0]       m0_we, m1_we;
    logic             m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0]      m0_rdata, m1_rdata;
    logic             ram_oe;
    logic [SCALE-1:0] ram_addr;
    logic [31:0]      ram_wdata;
    logic [3:0]       ram_we;
    logic [31:0]      ram_rdata;
    logic             err, err_src;

    ram_port_arbiter #(.SCALE(SCALE)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_oe(ram_oe), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .err(err), .err_src(err_src)
    );

    always #5 clk = ~clk;

    // Behavioural byte-lane RAM: registered read of the old word shifted down by addr[1:0].
    logic [31:0] ram_mem [0:WORDS-1];
    initial begin
        for (int i = 0; i < WORDS; i++) ram_mem[i] = 32'd0;
        ram_rdata = 32'd0;
    end
    always @(posedge clk) begin
        int sh;
        if (ram_oe) begin
            sh = int'(ram_addr[1:0]);
            ram_rdata <= ram_mem[ram_addr[SCALE-1:2]] >> (8 * sh);
            for (int b = 0; b < 4; b++)
                if (ram_we[b] && (sh + b) < 4)
                    ram_mem[ram_addr[SCALE-1:2]][8*(sh+b) +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [0:WORDS-1];
    int          last;
    logic        pv;
    int          po;
    logic [31:0] pd;
    logic        e_err;
    int          e_src;
    int          last_gnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_bad(input logic [3:0] we, input logic [SCALE-1:0] a);
        if (!(we inside {4'b0000, 4'b0001, 4'b0011, 4'b1111})) return 1'b1;
        if (we == 4'b1111 && a[1:0] != 2'd0) return 1'b1;
        if (we == 4'b0011 && a[1:0] == 2'd3) return 1'b1;
        return 1'b0;
    endfunction

    task automatic ref_access(input logic [SCALE-1:0] a, input logic [31:0] wd,
                              input logic [3:0] we, output logic [31:0] ret);
        int sh;
        sh  = int'(a[1:0]);
        ret = ref_mem[a[SCALE-1:2]] >> (8 * sh);
        for (int b = 0; b < 4; b++)
            if (we[b] && (sh + b) < 4)
                ref_mem[a[SCALE-1:2]][8*(sh+b) +: 8] = wd[8*b +: 8];
    endtask

    // One clock: check the return from last cycle, then this cycle's grant and RAM drive.
    task automatic cyc();
        logic             g0, g1, mis;
        logic [SCALE-1:0] a;
        logic [31:0]      wd, d;
        logic [3:0]       we;
        int               w;
        @(negedge clk);
        chk("m0_rvalid", 32'(m0_rvalid), 32'(!rst && pv && po == 0));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(!rst && pv && po == 1));
        chk("m0_rdata", m0_rdata, (!rst && pv && po == 0) ? pd : 32'd0);
        chk("m1_rdata", m1_rdata, (!rst && pv && po == 1) ? pd : 32'd0);
        chk("err", 32'(err), 32'(e_err));
        chk("err_src", 32'(err_src), 32'(e_src));
        g0 = 1'b0;
        g1 = 1'b0;
        if (!rst) begin
            if (m0_req && m1_req) begin
                g0 = (last == 1);
                g1 = (last == 0);
            end else begin
                g0 = m0_req;
                g1 = m1_req;
            end
        end
        chk("m0_gnt", 32'(m0_gnt), 32'(g0));
        chk("m1_gnt", 32'(m1_gnt), 32'(g1));
        last_gnt = -1;
        if (g0 || g1) begin
            w  = g1 ? 1 : 0;
            a  = g1 ? m1_addr  : m0_addr;
            wd = g1 ? m1_wdata : m0_wdata;
            we = g1 ? m1_we    : m0_we;
            mis = ref_bad(we, a);
            chk("ram_oe", 32'(ram_oe), 32'(!mis));
            chk("ram_addr", 32'(ram_addr), 32'(a));
            chk("ram_wdata", ram_wdata, wd);
            chk("ram_we", 32'(ram_we), 32'(we));
            if (mis) d = 32'd0;
            else     ref_access(a, wd, we, d);
            pv = 1'b1; po = w; pd = d;
            last = w;
            last_gnt = w;
            if (mis) begin
                if (!e_err) e_src = w;
                e_err = 1'b1;
            end
        end else begin
            chk("ram_oe_idle", 32'(ram_oe), 32'd0);
            chk("ram_addr_idle", 32'(ram_addr), 32'd0);
            chk("ram_we_idle", 32'(ram_we), 32'd0);
            pv = 1'b0;
        end
        if (rst) begin
            last = 1; pv = 1'b0; e_err = 1'b0; e_src = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rnd(inout logic req, inout logic [SCALE-1:0] a,
                       inout logic [31:0] wd, inout logic [3:0] we);
        if (req) begin
            if ($urandom_range(0, 15) == 0) req = 1'b0;
        end else if ($urandom_range(0, 2) != 0) begin
            req = 1'b1;
            a   = SCALE'($urandom_range(0, 63));
            wd  = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: we = 4'b0000;
                4, 5:       we = 4'b0001;
                6, 7:       we = 4'b0011;
                8:          we = 4'b1111;
                default:    we = 4'($urandom_range(0, 15));
            endcase
        end
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'd0;
        last = 1; pv = 1'b0; po = 0; pd = 32'd0; e_err = 1'b0; e_src = 0; last_gnt = -1;
        rst = 1'b1;
        m0_req = 1'b0; m0_addr = '0; m0_wdata = '0; m0_we = '0;
        m1_req = 1'b0; m1_addr = '0; m1_wdata = '0; m1_we = '0;
        repeat (2) cyc();
        m0_req = 1'b1; m1_req = 1'b1;
        cyc();
        m0_req = 1'b0; m1_req = 1'b0;
        rst = 1'b0;
        cyc();

        // Lone m0 read
        m0_req = 1'b1; m0_addr = 10'h010; m0_we = 4'b0000;
        cyc(); m0_req = 1'b0;
        cyc();

        // m1 alone, then both contend for six cycles
        m1_req = 1'b1; m1_addr = 10'h014; m1_we = 4'b0000;
        cyc(); m1_req = 1'b0;
        m0_req = 1'b1; m0_addr = 10'h018;
        m1_req = 1'b1; m1_addr = 10'h01c;
        repeat (6) cyc();
        m0_req = 1'b0; m1_req = 1'b0;
        cyc();

        // m1 word write then m0 reads it back
        m1_req = 1'b1; m1_addr = 10'h020; m1_wdata = 32'hA5A5_1234; m1_we = 4'b1111;
        cyc(); m1_req = 1'b0;
        m0_req = 1'b1; m0_addr = 10'h020; m0_we = 4'b0000;
        cyc(); m0_req = 1'b0;
        cyc();

        // Legal halfword write at offset 2
        m0_req = 1'b1; m0_addr = 10'h006; m0_wdata = 32'h0000_BEEF; m0_we = 4'b0011;
        cyc(); m0_req = 1'b0;
        cyc();

        // Misaligned word write by m0, then misaligned halfword by m1
        m0_req = 1'b1; m0_addr = 10'h022; m0_wdata = 32'hDEAD_BEEF; m0_we = 4'b1111;
        cyc(); m0_req = 1'b0;
        cyc();
        m1_req = 1'b1; m1_addr = 10'h023; m1_wdata = 32'h0000_CAFE; m1_we = 4'b0011;
        cyc(); m1_req = 1'b0;
        cyc();

        // Reset lands on an in-flight m1 return
        m1_req = 1'b1; m1_addr = 10'h020; m1_we = 4'b0000;
        cyc(); m1_req = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        m0_req = 1'b1; m0_addr = 10'h004; m0_we = 4'b0000;
        m1_req = 1'b1; m1_addr = 10'h008; m1_we = 4'b0000;
        cyc();
        m0_req = 1'b0; m1_req = 1'b0;
        cyc();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rnd(m0_req, m0_addr, m0_wdata, m0_we);
            rnd(m1_req, m1_addr, m1_wdata, m1_we);
            cyc();
            if (last_gnt == 0) m0_req = 1'b0;
            if (last_gnt == 1) m1_req = 1'b0;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
